// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM state encodings and derived-width helpers for the multi-cycle core.
package cpu_pkg;

   localparam logic [3:0] OP_AND  = 4'h0;
   localparam logic [3:0] OP_OR   = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h3;
   localparam logic [3:0] OP_DIV  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_NOR  = 4'h6;
   localparam logic [3:0] OP_ADDI = 4'h7;
   localparam logic [3:0] OP_STUR = 4'h8;
   localparam logic [3:0] OP_LDUR = 4'h9;
   localparam logic [3:0] OP_B    = 4'hA;
   localparam logic [3:0] OP_BZ   = 4'hB;
   localparam logic [3:0] OP_NOP  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   // A single-register file still needs a 1-bit select field.
   function automatic int unsigned ra_width(input int unsigned reg_count);
      return (reg_count > 1) ? $clog2(reg_count) : 1;
   endfunction

   function automatic int unsigned instr_width(input int unsigned imm_w,
                                               input int unsigned reg_count);
      return 4 + imm_w + 3 * ra_width(reg_count);
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multi-cycle core: result plus zero and carry/borrow/overflow flags.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 4
) (
   input  logic [3:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o,
   output logic              carry_o
);

   logic [DATA_W:0]     sum;
   logic [DATA_W:0]     diff;
   logic [2*DATA_W-1:0] prod;

   always_comb begin
      sum      = {1'b0, a_i} + {1'b0, b_i};
      diff     = {1'b0, a_i} - {1'b0, b_i};
      prod     = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
      result_o = '0;
      carry_o  = 1'b0;
      case (op_i)
         OP_AND:                             result_o = a_i & b_i;
         OP_OR:                              result_o = a_i | b_i;
         OP_NOR:                             result_o = ~(a_i | b_i);
         OP_ADD, OP_ADDI, OP_STUR, OP_LDUR:  {carry_o, result_o} = sum;
         // The extra top bit of the widened difference is the borrow.
         OP_SUB, OP_BZ:                      {carry_o, result_o} = diff;
         OP_MUL: begin
            result_o = prod[DATA_W-1:0];
            carry_o  = |prod[2*DATA_W-1:DATA_W];
         end
         OP_DIV: begin
            if (b_i == '0) begin
               result_o = '1;
               carry_o  = 1'b1;
            end else begin
               result_o = a_i / b_i;
            end
         end
         default: ;
      endcase
      zero_o = (result_o == '0);
   end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB FSM over a unified register file, with
// req/ack instruction and data memory ports, HALT, run gating and a debug read port.
module multicycle_cpu
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W    = 4,
   parameter int unsigned REG_COUNT = 4,
   parameter int unsigned PC_W      = 4,
   parameter int unsigned IMM_W     = 4,
   parameter int unsigned RA_W      = ra_width(REG_COUNT),
   parameter int unsigned INSTR_W   = instr_width(IMM_W, REG_COUNT)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DATA_W-1:0]  dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic               dmem_ack,
   input  logic [DATA_W-1:0]  dmem_rdata,
   output logic [PC_W-1:0]    pc,
   output logic               zero,
   output logic               carry,
   output logic               halted,
   output logic               retired,
   input  logic [RA_W-1:0]    dbg_addr,
   output logic [DATA_W-1:0]  dbg_data
);

   logic [2:0]         state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, res_q, res_d;
   logic               zero_q, zero_d, carry_q, carry_d;
   logic [DATA_W-1:0]  regs_q [REG_COUNT];
   logic [DATA_W-1:0]  regs_d [REG_COUNT];

   logic [3:0]        opcode;
   logic [IMM_W-1:0]  imm;
   logic [RA_W-1:0]   rz, rx, ry;
   logic [DATA_W-1:0] alu_b, alu_result;
   logic              alu_zero, alu_carry;
   logic              uses_imm, updates_flags, writes_reg;

   assign opcode = ir_q[INSTR_W-1 -: 4];
   assign imm    = ir_q[3*RA_W +: IMM_W];
   assign rz     = ir_q[2*RA_W +: RA_W];
   assign rx     = ir_q[RA_W +: RA_W];
   assign ry     = ir_q[0 +: RA_W];

   assign uses_imm      = (opcode == OP_ADDI) || (opcode == OP_STUR) || (opcode == OP_LDUR);
   assign updates_flags = !opcode[3] || (opcode == OP_BZ);
   assign writes_reg    = !opcode[3] || (opcode == OP_LDUR);
   assign alu_b         = uses_imm ? DATA_W'(imm) : b_q;

   cpu_alu #(
      .DATA_W(DATA_W)
   ) u_alu (
      .op_i    (opcode),
      .a_i     (a_q),
      .b_i     (alu_b),
      .result_o(alu_result),
      .zero_o  (alu_zero),
      .carry_o (alu_carry)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      res_d   = res_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      regs_d  = regs_q;
      case (state_q)
         ST_FETCH: begin
            if (run && imem_ack) begin
               ir_d    = imem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            a_d     = regs_q[rx];
            b_d     = regs_q[ry];
            c_d     = regs_q[rz];
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            res_d = alu_result;
            if (updates_flags) begin
               zero_d  = alu_zero;
               carry_d = alu_carry;
            end
            if ((opcode == OP_STUR) || (opcode == OP_LDUR)) begin
               state_d = ST_MEM;
            end else if (opcode == OP_HALT) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            // res_q holds the address until the ack, then the loaded data.
            if (dmem_ack) begin
               if (opcode == OP_LDUR) begin
                  res_d = dmem_rdata;
               end
               state_d = ST_WB;
            end
         end
         ST_WB: begin
            pc_d = pc_q + PC_W'(1);
            if (opcode == OP_B) begin
               pc_d = pc_q + PC_W'(imm);
            end else if ((opcode == OP_BZ) && zero_q) begin
               pc_d = pc_q + PC_W'(imm);
            end
            if (writes_reg) begin
               regs_d[rz] = res_q;
            end
            state_d = ST_FETCH;
         end
         ST_HALT: ;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         regs_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         regs_q  <= regs_d;
      end
   end

   assign imem_req   = run && (state_q == ST_FETCH) && !reset;
   assign imem_addr  = pc_q;
   assign dmem_req   = (state_q == ST_MEM);
   assign dmem_we    = dmem_req && (opcode == OP_STUR);
   assign dmem_addr  = res_q;
   assign dmem_wdata = c_q;
   assign pc         = pc_q;
   assign zero       = zero_q;
   assign carry      = carry_q;
   assign halted     = (state_q == ST_HALT);
   assign retired    = (state_q == ST_WB);
   assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: directed vector table, HALT and mid-MEM reset sequences, and
// randomized single instructions checked against a behavioural model of the ISA.
module tb_multicycle_cpu;

   localparam int DW      = 4;
   localparam int NREG    = 4;
   localparam int PCW     = 4;
   localparam int IW      = 4;
   localparam int RAW     = 2;
   localparam int INSTR_W = 14;
   localparam int DMASK   = (1 << DW) - 1;
   localparam int PMASK   = (1 << PCW) - 1;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               run = 1'b0;
   logic               imem_req;
   logic [PCW-1:0]     imem_addr;
   logic               imem_ack = 1'b0;
   logic [INSTR_W-1:0] imem_rdata = '0;
   logic               dmem_req, dmem_we;
   logic [DW-1:0]      dmem_addr, dmem_wdata;
   logic               dmem_ack = 1'b0;
   logic [DW-1:0]      dmem_rdata = '0;
   logic [PCW-1:0]     pc;
   logic               zero, carry, halted, retired;
   logic [RAW-1:0]     dbg_addr = '0;
   logic [DW-1:0]      dbg_data;

   int vectors = 0;
   int miscompares = 0;

   logic [INSTR_W-1:0] imem [16];
   logic [DW-1:0]      dmem [16];
   int ilat = 0, dlat = 0, iwait = 0, dwait = 0;

   // Behavioural model state
   int r_reg [NREG];
   int r_mem [16];
   int r_pc, r_z, r_c;

   typedef struct {
      int op, imm, rz, rx, ry, il, dl, er, epc, ez, ec, ecy;
   } vec_t;
   vec_t tbl [$];

   always #10 clock = ~clock;

   multicycle_cpu #(
      .DATA_W   (DW),
      .REG_COUNT(NREG),
      .PC_W     (PCW),
      .IMM_W    (IW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .run       (run),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_rdata(imem_rdata),
      .dmem_req  (dmem_req),
      .dmem_we   (dmem_we),
      .dmem_addr (dmem_addr),
      .dmem_wdata(dmem_wdata),
      .dmem_ack  (dmem_ack),
      .dmem_rdata(dmem_rdata),
      .pc        (pc),
      .zero      (zero),
      .carry     (carry),
      .halted    (halted),
      .retired   (retired),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory devices: ack after a programmable number of wait cycles, driven at negedge.
   always @(negedge clock) begin
      if (reset) begin
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         iwait    = 0;
         dwait    = 0;
      end else begin
         imem_ack = 1'b0;
         if (imem_req) begin
            if (iwait >= ilat) begin
               imem_ack   = 1'b1;
               imem_rdata = imem[imem_addr];
               iwait      = 0;
            end else begin
               iwait++;
            end
         end
         dmem_ack = 1'b0;
         if (dmem_req) begin
            if (dwait >= dlat) begin
               dmem_ack = 1'b1;
               if (dmem_we) dmem[dmem_addr] = dmem_wdata;
               dmem_rdata = dmem[dmem_addr];
               dwait      = 0;
            end else begin
               dwait++;
            end
         end
      end
   end

   // A pending data request must hold address, direction and store data stable.
   logic          prev_req = 1'b0;
   logic [8:0]    prev_bus = '0;
   always @(negedge clock) begin
      if (dmem_req && prev_req) begin
         check("dmem_stable", int'({dmem_we, dmem_addr, dmem_wdata}), int'(prev_bus));
      end
      prev_req = dmem_req;
      prev_bus = {dmem_we, dmem_addr, dmem_wdata};
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   function automatic logic [INSTR_W-1:0] enc(input int op, input int imm, input int rz,
                                              input int rx, input int ry);
      return {4'(op), 4'(imm), 2'(rz), 2'(rx), 2'(ry)};
   endfunction

   task automatic add_vec(input int op, imm, rz, rx, ry, il, dl, er, epc, ez, ec, ecy);
      vec_t v;
      v = '{op, imm, rz, rx, ry, il, dl, er, epc, ez, ec, ecy};
      tbl.push_back(v);
   endtask

   task automatic read_reg(input int idx, output int val);
      dbg_addr = RAW'(idx);
      #1;
      val = int'(dbg_data);
   endtask

   task automatic do_reset();
      run   = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   // Issues one instruction at pc_at; returns cycles from first FETCH to the retire/halt cycle.
   task automatic run_one(input logic [INSTR_W-1:0] instr, input int pc_at, input int il,
                          input int dl, output int cyc);
      bit done;
      imem[pc_at] = instr;
      ilat = il;
      dlat = dl;
      run  = 1'b1;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 60) begin
         @(negedge clock);
         cyc++;
         done = retired || halted;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL run_one: no retire/halt after %0d cycles, expected at most 60", cyc);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic model_step(input int op, input int imm, input int rz, input int rx,
                             input int ry);
      int x, y, res, old;
      bit wr, fl;
      x   = r_reg[rx];
      y   = r_reg[ry];
      old = r_pc;
      res = 0;
      wr  = 1'b1;
      fl  = 1'b1;
      r_pc = (old + 1) & PMASK;
      case (op)
         0:  begin res = x & y;  r_c = 0; end
         1:  begin res = x | y;  r_c = 0; end
         2:  begin res = x + y;  r_c = (res > DMASK); end
         3:  begin res = x * y;  r_c = ((res >> DW) != 0); end
         4:  begin
            if (y == 0) begin res = DMASK; r_c = 1; end
            else begin res = x / y; r_c = 0; end
         end
         5:  begin res = x - y;  r_c = (x < y); end
         6:  begin res = ~(x | y); r_c = 0; end
         7:  begin res = x + imm; r_c = (res > DMASK); end
         8:  begin r_mem[(x + imm) & DMASK] = r_reg[rz]; wr = 0; fl = 0; end
         9:  begin res = r_mem[(x + imm) & DMASK]; fl = 0; end
         10: begin r_pc = (old + imm) & PMASK; wr = 0; fl = 0; end
         11: begin
            res = x - y;
            r_c = (x < y);
            wr  = 0;
            if (x == y) r_pc = (old + imm) & PMASK;
         end
         default: begin wr = 0; fl = 0; end
      endcase
      res = res & DMASK;
      if (fl) r_z = (res == 0);
      if (wr) r_reg[rz] = res;
   endtask

   task automatic check_reset_state(input string tag);
      int v;
      check({tag, " pc"}, int'(pc), 0);
      check({tag, " zero"}, int'(zero), 0);
      check({tag, " carry"}, int'(carry), 0);
      check({tag, " halted"}, int'(halted), 0);
      check({tag, " retired"}, int'(retired), 0);
      check({tag, " imem_req"}, int'(imem_req), 0);
      check({tag, " dmem_req"}, int'(dmem_req), 0);
      check({tag, " dmem_we"}, int'(dmem_we), 0);
      for (int i = 0; i < NREG; i++) begin
         read_reg(i, v);
         check($sformatf("%s R%0d", tag, i), v, 0);
      end
   endtask

   initial begin
      int cyc, v, pc_now, bad, waited;

      //       op imm rz rx ry il dl  er epc ez ec cyc
      add_vec( 7,  9, 1, 0, 0, 0, 0,  9,  1, 0, 0, 4);
      add_vec( 7,  8, 2, 0, 0, 0, 0,  8,  2, 0, 0, 4);
      add_vec( 2,  0, 3, 1, 2, 0, 0,  1,  3, 0, 1, 4);
      add_vec( 7,  4, 3, 0, 0, 2, 0,  4,  4, 0, 0, 6);
      add_vec( 5,  0, 0, 3, 3, 0, 0,  0,  5, 1, 0, 4);
      add_vec(11,  3, 0, 3, 3, 0, 0,  0,  8, 1, 0, 4);
      add_vec(11,  3, 0, 1, 2, 0, 0,  0,  9, 0, 0, 4);
      add_vec( 7,  5, 0, 0, 0, 0, 0,  5, 10, 0, 0, 4);
      add_vec( 5,  0, 1, 1, 2, 0, 0,  1, 11, 0, 0, 4);
      add_vec( 8,  2, 0, 1, 0, 0, 3,  5, 12, 0, 0, 8);
      add_vec( 9,  2, 2, 1, 0, 1, 0,  5, 13, 0, 0, 6);
      add_vec( 7,  3, 3, 3, 0, 0, 0,  7, 14, 0, 0, 4);
      add_vec(10,  3, 3, 0, 0, 0, 0,  7,  1, 0, 0, 4);
      add_vec( 5,  0, 1, 1, 1, 0, 0,  0,  2, 1, 0, 4);
      add_vec( 4,  0, 0, 3, 1, 0, 0, 15,  3, 0, 1, 4);
      add_vec( 7,  4, 1, 1, 0, 0, 0,  4,  4, 0, 0, 4);
      add_vec( 3,  0, 3, 1, 2, 0, 0,  4,  5, 0, 1, 4);
      add_vec( 6,  0, 0, 1, 2, 0, 0, 10,  6, 0, 0, 4);
      add_vec( 4,  0, 2, 3, 1, 0, 0,  1,  7, 0, 0, 4);
      add_vec( 5,  0, 0, 1, 3, 0, 0,  0,  8, 1, 0, 4);
      add_vec( 5,  0, 0, 2, 1, 0, 0, 13,  9, 0, 1, 4);
      add_vec(12,  0, 0, 0, 0, 0, 0, 13, 10, 0, 1, 4);
      add_vec(10,  2, 0, 0, 0, 0, 0, 13, 12, 0, 1, 4);
      add_vec( 7, 15, 1, 1, 0, 0, 0,  3, 13, 0, 1, 4);
      add_vec( 0,  0, 0, 1, 2, 0, 0,  1, 14, 0, 0, 4);
      add_vec( 1,  0, 3, 1, 3, 0, 0,  7, 15, 0, 0, 4);
      add_vec( 7, 13, 2, 1, 0, 0, 0,  0,  0, 1, 1, 4);

      for (int i = 0; i < 16; i++) begin
         imem[i] = '0;
         dmem[i] = '0;
      end

      do_reset();
      check_reset_state("reset");

      pc_now = 0;
      foreach (tbl[i]) begin
         run_one(enc(tbl[i].op, tbl[i].imm, tbl[i].rz, tbl[i].rx, tbl[i].ry), pc_now,
                 tbl[i].il, tbl[i].dl, cyc);
         check($sformatf("vec%0d cycles", i), cyc, tbl[i].ecy);
         check($sformatf("vec%0d pc", i), int'(pc), tbl[i].epc);
         check($sformatf("vec%0d zero", i), int'(zero), tbl[i].ez);
         check($sformatf("vec%0d carry", i), int'(carry), tbl[i].ec);
         read_reg(tbl[i].rz, v);
         check($sformatf("vec%0d R%0d", i, tbl[i].rz), v, tbl[i].er);
         pc_now = tbl[i].epc;
      end

      // HALT: reached after FETCH/DECODE/EXEC, then no further fetches with run held high.
      run_one(enc(15, 0, 0, 0, 0), pc_now, 0, 0, cyc);
      check("halt cycles", cyc, 4);
      check("halt halted", int'(halted), 1);
      check("halt pc", int'(pc), pc_now);
      bad = 0;
      repeat (10) begin
         @(negedge clock);
         if (imem_req || retired || !halted) bad++;
      end
      check("halt quiet cycles", bad, 0);

      do_reset();
      check_reset_state("reset2");
      for (int i = 0; i < NREG; i++) r_reg[i] = 0;
      for (int i = 0; i < 16; i++) begin
         dmem[i]  = DW'($urandom);
         r_mem[i] = int'(dmem[i]);
      end
      r_pc = 0;
      r_z  = 0;
      r_c  = 0;

      for (int n = 0; n < 200; n++) begin
         int op, imm, rz, rx, ry, il, dl, ecy, addr;
         op  = $urandom_range(0, 14);
         imm = $urandom_range(0, 15);
         rz  = $urandom_range(0, NREG - 1);
         rx  = $urandom_range(0, NREG - 1);
         ry  = $urandom_range(0, NREG - 1);
         il  = $urandom_range(0, 2);
         dl  = $urandom_range(0, 2);
         ecy = 4 + il + (((op == 8) || (op == 9)) ? 1 + dl : 0);
         addr = (r_reg[rx] + imm) & DMASK;
         run_one(enc(op, imm, rz, rx, ry), r_pc, il, dl, cyc);
         model_step(op, imm, rz, rx, ry);
         check($sformatf("rnd%0d op%0d cycles", n, op), cyc, ecy);
         check($sformatf("rnd%0d op%0d pc", n, op), int'(pc), r_pc);
         check($sformatf("rnd%0d op%0d zero", n, op), int'(zero), r_z);
         check($sformatf("rnd%0d op%0d carry", n, op), int'(carry), r_c);
         for (int i = 0; i < NREG; i++) begin
            read_reg(i, v);
            check($sformatf("rnd%0d op%0d R%0d", n, op, i), v, r_reg[i]);
         end
         if (op == 8) check($sformatf("rnd%0d store mem", n), int'(dmem[addr]), r_mem[addr]);
      end

      // Reset while a store is waiting in MEM: requests and state clear immediately.
      ilat = 0;
      dlat = 30;
      imem[r_pc] = enc(8, 1, 0, 1, 2);
      run = 1'b1;
      waited = 0;
      while (!dmem_req && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      check("midmem reached", int'(dmem_req), 1);
      run = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("midmem dmem_req", int'(dmem_req), 0);
      check("midmem pc", int'(pc), 0);
      check("midmem halted", int'(halted), 0);
      for (int i = 0; i < NREG; i++) begin
         read_reg(i, v);
         check($sformatf("midmem R%0d", i), v, 0);
      end
      @(posedge clock);
      #1 reset = 1'b0;
      dlat = 0;
      repeat (2) begin
         @(negedge clock);
         check("run0 imem_req", int'(imem_req), 0);
      end
      @(posedge clock);
      #1 run = 1'b1;
      #1;
      check("restart imem_req", int'(imem_req), 1);
      check("restart imem_addr", int'(imem_addr), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
